booth_controller: RTL and testbench
===================================

# booth_controller

- Sequencing FSM for the radix-2 Booth multiplier datapath.
- Drives the load, clear and shift enables of the A, Q, M and Q₋₁ registers and the ALU add/subtract select.
- Reads back the Q[0]/Q₋₁ bit pair from the datapath.
- Runs a start/done handshake with the surrounding system.

## Interface
Parameters:
- N, 16, operand width in bits; number of Booth iterations (N ≥ 2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  reset, synchronous, active-high.
- start  input  1  request a multiplication; sampled only in IDLE.
- q0  input  1  current LSB of Q register.
- qm1  input  1  current Q₋₁ flip-flop value.
- ld_m  output  1  load multiplicand register M.
- ld_q  output  1  load multiplier register Q.
- clr_a  output  1  clear accumulator A.
- clr_qm1  output  1  clear Q₋₁ flip-flop.
- ld_a  output  1  load ALU result into A.
- add_sub  output  1  ALU select: 0 = A+M, 1 = A−M. Forced 0 whenever ld_a=0.
- shift  output  1  arithmetic right shift of {A,Q,Q₋₁} by one.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; product valid on the datapath.

## Operation
- States: IDLE, LOAD, EVAL, SHIFT, DONE. Encoding is free.
- All outputs are Moore, decoded from state, except ld_a/add_sub in EVAL, which also depend on q0/qm1.
- Internal down-counter cnt, width $clog2(N+1).
- IDLE:
  - All outputs 0.
  - start=1 → LOAD; otherwise stay.
- LOAD:
  - ld_m=ld_q=clr_a=clr_qm1=1 for one cycle.
  - cnt←N.
  - → EVAL.
- EVAL: decode {q0,qm1}.
  - 01: ld_a=1, add_sub=0.
  - 10: ld_a=1, add_sub=1.
  - 00/11: ld_a=0, add_sub=0.
  - Always → SHIFT (base build).
- SHIFT:
  - shift=1, cnt←cnt−1.
  - If cnt==1 at this edge → DONE; else → EVAL.
- DONE:
  - done=1, busy=1 for one cycle.
  - → IDLE unconditionally.
- start outside IDLE is ignored, including start held high through DONE.
- start held high continuously relaunches: IDLE is visited for exactly one cycle between runs.
- No two of ld_a, shift, ld_m/ld_q are ever high in the same cycle (base build).
- cnt never wraps. It is only decremented in SHIFT and is ≥1 there.

## Timing
- Reset: state=IDLE, cnt=0, every output 0, on the edge where reset=1.
- Reset has priority over all transitions, including mid-run. The next cycle is IDLE with all outputs 0; no done pulse.
- Let start=1 be sampled in IDLE at edge 0:
  - LOAD occupies cycle 1.
  - EVAL/SHIFT alternate over cycles 2…2N+1.
  - done=1 in cycle 2N+2.
  - busy falls in cycle 2N+3.
- Total latency start→done = 2N+2 cycles in the base build.
- q0/qm1 are sampled combinationally during EVAL. The datapath must present post-shift values one cycle after shift.

## Configuration
- Macro: BOOTH_SKIP_EN.
- Undefined: behaviour exactly as above; fixed 2N+2 latency.
- Defined: in EVAL with {q0,qm1} ∈ {00,11}:
  - assert shift=1 in EVAL itself (ld_a=0).
  - decrement cnt.
  - go directly to EVAL, or to DONE if cnt==1.
  - SHIFT is skipped.
- Defined: 01/10 pairs are unchanged, still EVAL→SHIFT.
- Defined: latency = N + k + 2, where k = number of add/sub iterations.

## Test plan
- Reset idle: assert reset 3 cycles → all outputs 0, busy=0. Hold start=0 10 cycles → no output toggles.
- Base run, N=4, bench drives {q0,qm1} = 10, 11, 01, 00 per EVAL:
  - cycle 1 LOAD strobes.
  - EVAL ld_a/add_sub = 1/1, 0/0, 1/0, 0/0.
  - shift in cycles 3, 5, 7, 9.
  - done in cycle 10.
- Datapath co-sim, N=8: multiply 7×(−3), −128×−128, 0×55 → A:Q = −21, 16384, 0 when done=1. Check all three under both macro settings.
- Reset mid-run: assert reset in the 3rd SHIFT → next cycle IDLE, outputs 0, no done. A new start completes normally in 2N+2.
- Start handling: start pulsed during EVAL → ignored. start held high → consecutive runs with exactly one IDLE cycle between done and the next LOAD.
- BOOTH_SKIP_EN, N=4, pairs 00, 00, 10, 11:
  - shift in EVAL cycles 2 and 3.
  - ld_a/add_sub = 1/1 in cycle 4, shift cycle 5.
  - shift in cycle 6.
  - done in cycle 7 (N+k+2 = 7).

Source files
------------

// File: rtl/booth_controller_if.sv
// Handshake and strobe bundle between the Booth sequencer and its datapath/system.
// master = surrounding system + datapath, slave = booth_controller.
interface booth_controller_if;
  logic start;
  logic q0;
  logic qm1;
  logic ld_m;
  logic ld_q;
  logic clr_a;
  logic clr_qm1;
  logic ld_a;
  logic add_sub;
  logic shift;
  logic busy;
  logic done;

  modport master (
    output start, q0, qm1,
    input  ld_m, ld_q, clr_a, clr_qm1, ld_a, add_sub, shift, busy, done
  );

  modport slave (
    input  start, q0, qm1,
    output ld_m, ld_q, clr_a, clr_qm1, ld_a, add_sub, shift, busy, done
  );
endinterface

// File: rtl/booth_controller.sv
// Radix-2 Booth multiplier sequencer: LOAD, then N EVAL/SHIFT iterations, then a one-cycle done pulse.
// Macro BOOTH_SKIP_EN: on a 00/11 bit pair EVAL shifts by itself and the SHIFT state is skipped.
module booth_controller #(
  parameter int N = 16
) (
  input logic           clk,
  input logic           reset,
  booth_controller_if.slave bus
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(N);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EVAL,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          last;

  // cnt holds the iterations still to shift; it is >= 1 whenever a shift happens
  assign last = (cnt == CNT_ONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    bus.ld_m    = 1'b0;
    bus.ld_q    = 1'b0;
    bus.clr_a   = 1'b0;
    bus.clr_qm1 = 1'b0;
    bus.ld_a    = 1'b0;
    bus.add_sub = 1'b0;
    bus.shift   = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start) state_nx = S_LOAD;
      end

      S_LOAD: begin
        bus.busy    = 1'b1;
        bus.ld_m    = 1'b1;
        bus.ld_q    = 1'b1;
        bus.clr_a   = 1'b1;
        bus.clr_qm1 = 1'b1;
        cnt_nx      = CNT_LOAD;
        state_nx    = S_EVAL;
      end

      S_EVAL: begin
        bus.busy = 1'b1;
        state_nx = S_SHIFT;
        case ({bus.q0, bus.qm1})
          2'b01: bus.ld_a = 1'b1;
          2'b10: begin
            bus.ld_a    = 1'b1;
            bus.add_sub = 1'b1;
          end
          default: begin
`ifdef BOOTH_SKIP_EN
            // No ALU work this iteration, so shift now and stay in EVAL
            bus.shift = 1'b1;
            cnt_nx    = cnt - CNT_ONE;
            state_nx  = last ? S_DONE : S_EVAL;
`else
            bus.ld_a  = 1'b0;
`endif
          end
        endcase
      end

      S_SHIFT: begin
        bus.busy  = 1'b1;
        bus.shift = 1'b1;
        cnt_nx    = cnt - CNT_ONE;
        state_nx  = last ? S_DONE : S_EVAL;
      end

      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        state_nx = S_IDLE;
      end

      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_booth_controller.sv
// Directed bench: N=4 controller driven by hand-picked bit pairs, N=8 controller closed over a datapath model.
module tb_booth_controller;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  booth_controller_if bus4 ();
  booth_controller_if bus8 ();

  booth_controller #(.N(4)) u4 (.clk(clk), .reset(reset), .bus(bus4));
  booth_controller #(.N(8)) u8 (.clk(clk), .reset(reset), .bus(bus8));

  int checks   = 0;
  int failures = 0;

  // {ld_m, ld_q, clr_a, clr_qm1, ld_a, add_sub, shift, busy, done}
  localparam logic [8:0] O_IDLE = 9'b0000_0000_0;
  localparam logic [8:0] O_LOAD = 9'b1111_0001_0;
  localparam logic [8:0] O_ADD  = 9'b0000_1001_0;
  localparam logic [8:0] O_SUB  = 9'b0000_1101_0;
  localparam logic [8:0] O_NOP  = 9'b0000_0001_0;
  localparam logic [8:0] O_SHF  = 9'b0000_0011_0;
  localparam logic [8:0] O_DONE = 9'b0000_0000_1_1 >> 1 | 9'b0000_0001_1;

  logic [8:0] o4;
  logic [8:0] o8;
  assign o4 = {bus4.ld_m, bus4.ld_q, bus4.clr_a, bus4.clr_qm1, bus4.ld_a,
               bus4.add_sub, bus4.shift, bus4.busy, bus4.done};
  assign o8 = {bus8.ld_m, bus8.ld_q, bus8.clr_a, bus8.clr_qm1, bus8.ld_a,
               bus8.add_sub, bus8.shift, bus8.busy, bus8.done};

  // N=8 datapath model; A carries one guard bit so -128 * -128 does not overflow
  logic [7:0] mcand;
  logic [7:0] mplier;
  logic [8:0] a_r;
  logic [8:0] m_r;
  logic [7:0] q_r;
  logic       qm1_r;

  always @(posedge clk) begin
    if (reset) begin
      a_r   <= '0;
      m_r   <= '0;
      q_r   <= '0;
      qm1_r <= 1'b0;
    end else begin
      if (bus8.ld_m)    m_r   <= {mcand[7], mcand};
      if (bus8.ld_q)    q_r   <= mplier;
      if (bus8.clr_a)   a_r   <= '0;
      if (bus8.clr_qm1) qm1_r <= 1'b0;
      if (bus8.ld_a)    a_r   <= bus8.add_sub ? a_r - m_r : a_r + m_r;
      if (bus8.shift)   {a_r, q_r, qm1_r} <= {a_r[8], a_r, q_r};
    end
  end

  assign bus8.q0  = q_r[0];
  assign bus8.qm1 = qm1_r;

  logic [1:0] tpr [1:12];
  logic [8:0] tex [1:12];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_table(input string tag, input int len);
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    for (int c = 1; c <= len; c++) begin
      {bus4.q0, bus4.qm1} = tpr[c];
      #1;
      chk($sformatf("%s_c%0d", tag, c), o4, tex[c]);
      tick();
    end
  endtask

  task automatic run_lat(input string tag, input logic [1:0] pr, input int lat);
    int seen = 0;
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    for (int c = 1; c <= 60 && seen == 0; c++) begin
      {bus4.q0, bus4.qm1} = pr;
      #1;
      if (bus4.done) seen = c;
      tick();
    end
    chk({tag, "_lat"}, seen, lat);
    #1;
    chk({tag, "_idle"}, o4, O_IDLE);
  endtask

  task automatic mul8(input string tag, input logic [7:0] mc, input logic [7:0] mp,
                      input logic [15:0] prod, input int lat);
    int         seen = 0;
    logic [15:0] got = '0;
    mcand      = mc;
    mplier     = mp;
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    for (int c = 1; c <= 80 && seen == 0; c++) begin
      #1;
      if (bus8.done) begin
        seen = c;
        got  = {a_r[7:0], q_r};
      end
      tick();
    end
    chk({tag, "_prod"}, got, prod);
    chk({tag, "_lat"}, seen, lat);
  endtask

  initial begin
    bus4.start = 1'b0;
    bus4.q0    = 1'b0;
    bus4.qm1   = 1'b0;
    bus8.start = 1'b0;
    mcand      = '0;
    mplier     = '0;

    // Reset held three cycles, then ten quiet cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk($sformatf("rst_u4_%0d", i), o4, O_IDLE);
      chk($sformatf("rst_u8_%0d", i), o8, O_IDLE);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      chk($sformatf("quiet_%0d", i), o4, O_IDLE);
    end

`ifdef BOOTH_SKIP_EN
    tpr = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tex = '{O_LOAD, O_SHF, O_SHF, O_SUB, O_SHF, O_SHF, O_DONE, O_IDLE,
            O_IDLE, O_IDLE, O_IDLE, O_IDLE};
    run_table("skip", 8);
    mul8("m7xn3",     8'd7,   8'hFD, 16'hFFEB, 13);
    mul8("n128xn128", 8'h80,  8'h80, 16'h4000, 11);
    mul8("m0x55",     8'd0,   8'd55, 16'h0000, 14);
`else
    tpr = '{2'b00, 2'b10, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tex = '{O_LOAD, O_SUB, O_SHF, O_NOP, O_SHF, O_ADD, O_SHF, O_NOP,
            O_SHF, O_DONE, O_IDLE, O_IDLE};
    run_table("base", 12);
    mul8("m7xn3",     8'd7,   8'hFD, 16'hFFEB, 18);
    mul8("n128xn128", 8'h80,  8'h80, 16'h4000, 18);
    mul8("m0x55",     8'd0,   8'd55, 16'h0000, 18);
`endif

    // Reset during the third SHIFT (all-subtract pairs keep the same timing in both builds)
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      {bus4.q0, bus4.qm1} = 2'b10;
      tick();
    end
    #1;
    chk("mid_shift3", o4, O_SHF);
    reset = 1'b1;
    tick();
    #1;
    chk("mid_rst_idle", o4, O_IDLE);
    reset = 1'b0;
    tick();
    #1;
    chk("mid_rst_nodone", o4, O_IDLE);
    run_lat("restart", 2'b10, 10);

    // start pulsed during EVAL must not relaunch
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      {bus4.q0, bus4.qm1} = 2'b10;
      bus4.start = (c == 2);
      #1;
      if (c == 2)  chk("ign_eval", o4, O_SUB);
      if (c == 10) chk("ign_done", o4, O_DONE);
      if (c >= 11) chk($sformatf("ign_idle_%0d", c), o4, O_IDLE);
      tick();
    end

    // start held high: one IDLE cycle between DONE and the next LOAD
    bus4.start = 1'b1;
    tick();
    for (int c = 1; c <= 21; c++) begin
      {bus4.q0, bus4.qm1} = 2'b10;
      #1;
      if (c == 1)  chk("held_load1", o4, O_LOAD);
      if (c == 10) chk("held_done1", o4, O_DONE);
      if (c == 11) chk("held_gap",   o4, O_IDLE);
      if (c == 12) chk("held_load2", o4, O_LOAD);
      if (c == 21) chk("held_done2", o4, O_DONE);
      tick();
    end
    bus4.start = 1'b0;
    #1;
    chk("held_end_idle", o4, O_IDLE);
    tick();
    #1;
    chk("held_end_stay", o4, O_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
